vc_out_arbiter: RTL and testbench

Per-input-port virtual-channel arbiter that sits directly downstream of the `vc_buffer` instances of one router input. It selects one VC per cycle, forwards its flits through a registered valid/ready output toward the crossbar, and holds the selection for the whole packet (wormhole lock) from head flit to tail flit. Selection among competing head flits is round-robin.

---
 rtl/vc_out_arbiter.sv | 157 +++++++++++++++
 tb/tb_vc_out_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_out_arbiter.sv
// vc_out_arbiter
// Chooses one of N_VC input virtual channels per cycle and forwards its flit
// through a single registered output stage toward the crossbar. Once a head
// flit is granted the arbiter stays on that VC until its tail flit has been
// popped (wormhole lock). Competing head flits are served round-robin.
//
// Handshake: each side uses strict valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Upstream, vc_ready_o[k] acts as the
// pop strobe for VC k and is only ever raised while vc_valid_i[k] is high.
// Downstream, valid_o/fdata_o/vc_id_o stay stable until ready_i accepts them.
module vc_out_arbiter #(
   parameter int N_VC = 4,
   parameter int FLIT_W = 34,
   localparam int VC_W = $clog2(N_VC)
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [N_VC-1:0]          vc_valid_i,
   input  logic [N_VC*FLIT_W-1:0]   vc_fdata_i,
   output logic [N_VC-1:0]          vc_ready_o,
   output logic [FLIT_W-1:0]        fdata_o,
   output logic [VC_W-1:0]          vc_id_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     err_o,
   output logic                     state_o
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
   logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [VC_W-1:0]   vc_id_q, vc_id_d;
   logic [FLIT_W-1:0] fdata_q, fdata_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic [1:0]        vc_type [N_VC];
   logic [N_VC-1:0]   cand;
   logic              grant_found;
   logic [VC_W-1:0]   grant_idx;
   logic              adv;
   logic              pop;
   logic [VC_W-1:0]   pop_idx;
   logic [N_VC-1:0]   pop_vec;

   // Split out each VC's flit type; only head types (bit 0 clear) may start a packet.
   always_comb begin
      for (int k = 0; k < N_VC; k++) begin
         vc_type[k] = vc_fdata_i[k*FLIT_W + FLIT_W - 2 +: 2];
         cand[k]    = vc_valid_i[k] && !vc_type[k][0];
      end
   end

   // Round-robin search for the first head candidate after the last grant, wrapping.
   always_comb begin
      logic [VC_W-1:0] idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int i = 1; i <= N_VC; i++) begin
         idx = rr_ptr_q + VC_W'(i);
         if (!grant_found && cand[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   // Next-state, pop decision and output-register load for the lock FSM.
   always_comb begin
      adv       = !valid_q || ready_i;
      pop       = 1'b0;
      pop_idx   = '0;
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      rr_ptr_d  = rr_ptr_q;
      valid_d   = valid_q;
      fdata_d   = fdata_q;
      vc_id_d   = vc_id_q;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_found && adv) begin
               pop      = 1'b1;
               pop_idx  = grant_idx;
               rr_ptr_d = grant_idx;
               if (vc_type[grant_idx] == 2'b00) begin
                  state_d   = ST_LOCKED;
                  lock_vc_d = grant_idx;
               end
            end
            // Something is waiting but none of it can open a packet.
            if ((cand == '0) && (vc_valid_i != '0)) begin
               err_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (vc_valid_i[lock_vc_q] && adv) begin
               pop     = 1'b1;
               pop_idx = lock_vc_q;
               case (vc_type[lock_vc_q])
                  2'b11:        state_d = ST_IDLE;
                  2'b00, 2'b10: err_d   = 1'b1;
                  default:      ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         valid_d = 1'b1;
         fdata_d = vc_fdata_i[pop_idx*FLIT_W +: FLIT_W];
         vc_id_d = pop_idx;
      end else if (adv) begin
         valid_d = 1'b0;
      end

      pop_vec          = '0;
      pop_vec[pop_idx] = pop;
   end

   // State and output registers; reset drops any lock and empties the output stage.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q   <= ST_IDLE;
         lock_vc_q <= '0;
         rr_ptr_q  <= VC_W'(N_VC - 1);
         valid_q   <= 1'b0;
         fdata_q   <= '0;
         vc_id_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
         rr_ptr_q  <= rr_ptr_d;
         valid_q   <= valid_d;
         fdata_q   <= fdata_d;
         vc_id_q   <= vc_id_d;
         err_q     <= err_d;
      end
   end

   assign vc_ready_o = arst ? pop_vec : '0;
   assign fdata_o    = fdata_q;
   assign vc_id_o    = vc_id_q;
   assign valid_o    = valid_q;
   assign err_o      = err_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Bench for vc_out_arbiter: directed cycle table, a reset-while-locked
// sequence, then random traffic checked against a packet-level model.
module tb_vc_out_arbiter;

   localparam int N_VC   = 4;
   localparam int FLIT_W = 34;
   localparam int VC_W   = 2;
   localparam int EW     = VC_W + FLIT_W;

   localparam logic [1:0] H = 2'b00;
   localparam logic [1:0] B = 2'b01;
   localparam logic [1:0] T = 2'b11;
   localparam logic [1:0] S = 2'b10;
   localparam logic [1:0] X = 2'b00;

   logic                   clk;
   logic                   arst;
   logic [N_VC-1:0]        vc_valid_i;
   logic [N_VC*FLIT_W-1:0] vc_fdata_i;
   logic [N_VC-1:0]        vc_ready_o;
   logic [FLIT_W-1:0]      fdata_o;
   logic [VC_W-1:0]        vc_id_o;
   logic                   valid_o;
   logic                   ready_i;
   logic                   err_o;
   logic                   state_o;

   int checks   = 0;
   int failures = 0;

   vc_out_arbiter #(.N_VC(N_VC), .FLIT_W(FLIT_W)) dut (
      .clk        (clk),
      .arst       (arst),
      .vc_valid_i (vc_valid_i),
      .vc_fdata_i (vc_fdata_i),
      .vc_ready_o (vc_ready_o),
      .fdata_o    (fdata_o),
      .vc_id_o    (vc_id_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .err_o      (err_o),
      .state_o    (state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int vc, input int n);
      return {t, 32'(vc * 256 + n)};
   endfunction

   typedef struct {
      logic [3:0] vld;
      logic [7:0] typ;
      logic       rdy;
      logic [3:0] e_rdy;
      logic       e_valid;
      logic [1:0] e_id;
      logic       e_err;
      logic       e_state;
   } vec_t;

   function automatic vec_t v(input logic [3:0] vld, input logic [7:0] typ, input logic rdy,
                              input logic [3:0] e_rdy, input logic e_valid, input logic [1:0] e_id,
                              input logic e_err, input logic e_state);
      vec_t r;
      r.vld = vld; r.typ = typ; r.rdy = rdy; r.e_rdy = e_rdy;
      r.e_valid = e_valid; r.e_id = e_id; r.e_err = e_err; r.e_state = e_state;
      return r;
   endfunction

   // ---------------- buffer model and scoreboard ----------------
   logic [FLIT_W-1:0] vcq [N_VC][$];
   logic [EW-1:0]     exp_q[$];

   vec_t              tbl [34];
   logic [FLIT_W-1:0] exp_fd;

   int  owner;
   int  last;
   bit  m_valid;
   int  seq;

   task automatic add_packet(input int vc);
      int len;
      len = $urandom_range(1, 4);
      if (len == 1) begin
         vcq[vc].push_back(mk(S, vc, seq)); seq++;
      end else begin
         vcq[vc].push_back(mk(H, vc, seq)); seq++;
         for (int i = 0; i < len - 2; i++) begin
            vcq[vc].push_back(mk(B, vc, seq)); seq++;
         end
         vcq[vc].push_back(mk(T, vc, seq)); seq++;
      end
   endtask

   // One random-phase cycle; entered and left at posedge+1.
   task automatic rand_cycle(input bit allow_new, input bit gate_rand, input bit rdy_rand);
      logic [N_VC-1:0]   vld;
      logic              rdy;
      logic [FLIT_W-1:0] f;
      logic [N_VC-1:0]   exp_rdy;
      logic [EW-1:0]     e;
      int                pv;
      bit                adv;

      if (allow_new && ($urandom_range(0, 2) == 0)) begin
         pv = $urandom_range(0, N_VC - 1);
         if (vcq[pv].size() < 12) add_packet(pv);
      end
      vc_fdata_i = '0;
      for (int k = 0; k < N_VC; k++) begin
         vld[k] = (vcq[k].size() > 0) && (!gate_rand || ($urandom_range(0, 3) != 0));
         if (vcq[k].size() > 0) vc_fdata_i[k*FLIT_W +: FLIT_W] = vcq[k][0];
      end
      rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      vc_valid_i = vld;
      ready_i    = rdy;
      #2;

      // Packet-level prediction of this cycle's pop.
      adv = !m_valid || rdy;
      pv  = -1;
      if (adv) begin
         if (owner < 0) begin
            for (int i = 1; i <= N_VC; i++) begin
               int k;
               k = (last + i) % N_VC;
               if (pv < 0 && vld[k]) begin
                  f = vcq[k][0];
                  if (f[FLIT_W-1 -: 2] == H || f[FLIT_W-1 -: 2] == S) pv = k;
               end
            end
         end else if (vld[owner]) begin
            pv = owner;
         end
      end
      exp_rdy = '0;
      if (pv >= 0) exp_rdy[pv] = 1'b1;

      chk("rand_vc_ready", 64'(vc_ready_o), 64'(exp_rdy));
      chk("rand_valid_o", 64'(valid_o), 64'(m_valid));
      chk("rand_err_o", 64'(err_o), 64'd0);

      if (m_valid && rdy) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rand_out: output transfer with empty expected queue");
         end else begin
            e = exp_q.pop_front();
            chk("rand_out_flit", 64'({vc_id_o, fdata_o}), 64'(e));
         end
      end

      if (pv >= 0) begin
         f = vcq[pv][0];
         exp_q.push_back({VC_W'(pv), f});
         m_valid = 1'b1;
         if (owner < 0) begin
            last = pv;
            if (f[FLIT_W-1 -: 2] == H) owner = pv;
         end else if (f[FLIT_W-1 -: 2] == T) begin
            owner = -1;
         end
      end else if (adv) begin
         m_valid = 1'b0;
      end

      // The buffers pop on the DUT's strobe, as real vc_buffers would.
      for (int k = 0; k < N_VC; k++) begin
         if (vc_ready_o[k] && vcq[k].size() > 0) void'(vcq[k].pop_front());
      end

      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int pending;
      arst       = 1'b1;
      vc_valid_i = '0;
      vc_fdata_i = '0;
      ready_i    = 1'b1;
      seq        = 0;
      #1;
      arst = 1'b0;
      vc_valid_i = 4'b1111;
      for (int k = 0; k < N_VC; k++) vc_fdata_i[k*FLIT_W +: FLIT_W] = mk(H, k, 0);
      #2;
      chk("reset_vc_ready", 64'(vc_ready_o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid_o", 64'(valid_o), 64'd0);
      chk("reset_fdata_o", 64'(fdata_o), 64'd0);
      chk("reset_vc_id_o", 64'(vc_id_o), 64'd0);
      chk("reset_err_o", 64'(err_o), 64'd0);
      chk("reset_state", 64'(state_o), 64'd0);
      vc_valid_i = '0;
      arst       = 1'b1;

      // ---- directed cycle table ----
      tbl[0]  = v(4'b0100, {X, H, X, X}, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
      tbl[1]  = v(4'b0100, {X, B, X, X}, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
      tbl[2]  = v(4'b0100, {X, T, X, X}, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
      tbl[3]  = v(4'b0000, {X, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
      tbl[4]  = v(4'b0011, {X, X, H, H}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      tbl[5]  = v(4'b0011, {X, X, H, B}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      tbl[6]  = v(4'b0011, {X, X, H, T}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
      tbl[7]  = v(4'b0010, {X, X, H, X}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
      tbl[8]  = v(4'b0010, {X, X, B, X}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
      tbl[9]  = v(4'b0010, {X, X, T, X}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
      tbl[10] = v(4'b1000, {H, X, X, X}, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
      tbl[11] = v(4'b1000, {B, X, X, X}, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1);
      tbl[12] = v(4'b1000, {B, X, X, X}, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1);
      tbl[13] = v(4'b1000, {B, X, X, X}, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1);
      tbl[14] = v(4'b1000, {B, X, X, X}, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
      tbl[15] = v(4'b1000, {T, X, X, X}, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
      tbl[16] = v(4'b0000, {X, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
      for (int i = 17; i <= 24; i++) begin
         logic [3:0] oh;
         oh = 4'b0001 << ((i - 17) % 4);
         tbl[i] = v(4'b1111, {S, S, S, S}, 1'b1, oh, 1'b1, 2'((i - 17) % 4), 1'b0, 1'b0);
      end
      tbl[25] = v(4'b0000, {X, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
      tbl[26] = v(4'b1000, {B, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
      tbl[27] = v(4'b1000, {B, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
      tbl[28] = v(4'b0000, {X, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
      tbl[29] = v(4'b0001, {X, X, X, H}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      tbl[30] = v(4'b0001, {X, X, X, H}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1);
      tbl[31] = v(4'b0011, {X, X, S, T}, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
      tbl[32] = v(4'b0010, {X, X, S, X}, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
      tbl[33] = v(4'b0000, {X, X, X, X}, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);

      exp_fd = '0;
      for (int i = 0; i < 34; i++) begin
         vc_valid_i = tbl[i].vld;
         ready_i    = tbl[i].rdy;
         for (int k = 0; k < N_VC; k++)
            vc_fdata_i[k*FLIT_W +: FLIT_W] = mk(tbl[i].typ[2*k +: 2], k, i);
         #2;
         chk($sformatf("row%0d_vc_ready", i), 64'(vc_ready_o), 64'(tbl[i].e_rdy));
         if (tbl[i].e_rdy != 4'b0000)
            exp_fd = mk(tbl[i].typ[2*tbl[i].e_id +: 2], int'(tbl[i].e_id), i);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_valid_o", i), 64'(valid_o), 64'(tbl[i].e_valid));
         chk($sformatf("row%0d_vc_id_o", i), 64'(vc_id_o), 64'(tbl[i].e_id));
         chk($sformatf("row%0d_fdata_o", i), 64'(fdata_o), 64'(exp_fd));
         chk($sformatf("row%0d_err_o", i), 64'(err_o), 64'(tbl[i].e_err));
         chk($sformatf("row%0d_state", i), 64'(state_o), 64'(tbl[i].e_state));
      end

      // ---- reset while locked on VC1 ----
      vc_valid_i = 4'b0010;
      vc_fdata_i = '0;
      vc_fdata_i[1*FLIT_W +: FLIT_W] = mk(H, 1, 100);
      ready_i = 1'b1;
      #2;
      chk("rst_seq_grant_vc1", 64'(vc_ready_o), 64'b0010);
      @(posedge clk);
      #1;
      chk("rst_seq_locked", 64'(state_o), 64'd1);
      chk("rst_seq_valid", 64'(valid_o), 64'd1);
      vc_fdata_i[1*FLIT_W +: FLIT_W] = mk(B, 1, 101);
      #2;
      arst = 1'b0;
      #1;
      chk("rst_seq_valid_drop", 64'(valid_o), 64'd0);
      chk("rst_seq_state_drop", 64'(state_o), 64'd0);
      chk("rst_seq_ready_gated", 64'(vc_ready_o), 64'd0);
      @(posedge clk);
      #1;
      arst       = 1'b1;
      vc_valid_i = 4'b0011;
      vc_fdata_i[0*FLIT_W +: FLIT_W] = mk(H, 0, 102);
      vc_fdata_i[1*FLIT_W +: FLIT_W] = mk(H, 1, 103);
      #2;
      chk("rst_seq_vc0_first", 64'(vc_ready_o), 64'b0001);
      @(posedge clk);
      #1;
      chk("rst_seq_vc0_id", 64'(vc_id_o), 64'd0);
      chk("rst_seq_vc0_data", 64'(fdata_o), 64'(mk(H, 0, 102)));

      // ---- random traffic against the packet model ----
      vc_valid_i = '0;
      arst = 1'b0;
      @(posedge clk);
      #1;
      arst    = 1'b1;
      owner   = -1;
      last    = N_VC - 1;
      m_valid = 1'b0;
      for (int c = 0; c < 2000; c++) rand_cycle(1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 600; c++) begin
         pending = exp_q.size() + (m_valid ? 1 : 0);
         for (int k = 0; k < N_VC; k++) pending += vcq[k].size();
         if (pending == 0) break;
         rand_cycle(1'b0, 1'b0, 1'b0);
      end
      pending = exp_q.size();
      for (int k = 0; k < N_VC; k++) pending += vcq[k].size();
      chk("drain_all_delivered", 64'(pending), 64'd0);
      chk("drain_output_empty", 64'(valid_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
